vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
Single-port framebuffer arbiter for the VGA output path, driven by the free-running horizontal counter (0..3199, 4 clk per pixel, 800 pixels/line) and vertical counter (0..520, 521 lines/frame).
- Reserves one memory cycle per active pixel to prefetch display data.
- Grants all other cycles to one drawing/CPU requester through a req/ack handshake.
- Outputs registered pixel colour and blank, aligned to the pixel period.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SCALE_SHIFT, 2, framebuffer down-scale (log2); default gives 160x120 words
ADDR_W, 15, framebuffer address width
COLOR_W, 12, pixel word width
BLANK_ONLY, 0, 1 = requester granted only during vertical blanking

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
H_counter  in  12  horizontal timing count 0..3199
V_counter  in  10  vertical timing count 0..520
mem_addr  out  ADDR_W  framebuffer address (combinational, valid in slot/grant cycle)
mem_we  out  1  framebuffer write enable
mem_wdata  out  COLOR_W  framebuffer write data
mem_rdata  in  COLOR_W  synchronous read data, valid the cycle after the address
req  in  1  requester access request, held until req_ack
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  requester address
req_wdata  in  COLOR_W  requester write data
req_ack  out  1  one-cycle completion pulse
req_rdata  out  COLOR_W  read data, valid while req_ack = 1
rgb  out  COLOR_W  current pixel colour
blank  out  1  1 = current pixel outside the active area
frame_start  out  1  one-cycle pulse at frame wrap

Behaviour:
- Reset values: rgb = 0, blank = 1, req_ack = 0, req_rdata = 0, frame_start = 0, arbiter state = IDLE. In-flight access is abandoned and ack is never issued. A write takes effect only if its clock edge preceded reset.
- Pixel index and phase: px = H_counter[11:2], phase = H_counter[1:0].
- Display slot: any cycle with phase == 2.
  - Target pixel: tx = (px + 1) mod 800.
  - Target line: ty = V_counter if H_counter < 3196, else (V_counter + 1) mod 521.
- A display slot is active only if tx < H_ACTIVE and ty < V_ACTIVE. In an active slot:
  - mem_we = 0.
  - mem_addr = (ty >> SCALE_SHIFT) * (H_ACTIVE >> SCALE_SHIFT) + (tx >> SCALE_SHIFT), truncated to ADDR_W.
- Edge ending a phase-3 cycle:
  - rgb <= mem_rdata if the preceding slot was active, else 0.
  - blank <= NOT(preceding slot active).
  - Result: rgb/blank change exactly when phase returns to 0 and hold for 4 cycles.
- Display slots are never pre-empted.
- Requester FSM: IDLE -> DATA -> ACK -> IDLE.
  - IDLE, grant cycle: req = 1 and the cycle is not an active display slot, and (BLANK_ONLY = 0 or 480 <= V_counter <= 519). In the grant cycle mem_addr = req_addr, mem_we = req_we, mem_wdata = req_wdata; next state DATA.
  - DATA: memory not driven by the requester. At the end of DATA, req_rdata <= mem_rdata (reads only; writes leave req_rdata unchanged) and req_ack <= 1. Next state ACK.
  - ACK: req_ack = 1 for exactly one cycle; req is ignored. Next state IDLE.
  - The requester drops req, or presents a new request, in the cycle after it sees req_ack.
  - Minimum 3 cycles per access. Worst-case wait with BLANK_ONLY = 0 is 1 extra cycle.
- When no slot and no grant: mem_we = 0, mem_addr = 0.
- A display slot may coincide with DATA or ACK; there is no conflict.
- frame_start <= 1 on the edge ending a cycle with H_counter == 3199 and V_counter == 520; otherwise 0.
- Out-of-range counter values (H > 3199, V > 520): treated as blanking, with no display slot.

Test Plan:
- Reset mid-frame with req held high -> rgb = 0, blank = 1, req_ack = 0. After release, the first ack comes no earlier than 3 cycles later.
- Framebuffer word 0 = 0xF00, word 1 = 0x0F0. At H = 3198, V = 520: mem_addr = 0. From H = 0, V = 0: rgb = 0xF00 and blank = 0 for H 0..15; at H = 16, rgb = 0x0F0.
- Line 479 ends at H = 2559. At H = 2560: rgb = 0, blank = 1, and no further active slots on that line. Line 480 has no active slots.
- Write req (addr 0x0005, data 0xABC) asserted at H = 2 (a slot cycle) -> grant at H = 3 with mem_we = 1, req_ack at H = 5. A subsequent read of 0x0005 returns req_rdata = 0xABC with the ack.
- BLANK_ONLY = 1, req asserted at V = 100 -> no grant until V = 480, H = 0. A req still pending at V = 520 is not granted until V = 480 of the next frame.
- Counters stepped through a full frame -> exactly one frame_start pulse, on the edge after H = 3199, V = 520. 640 x 480 rgb updates, each with blank = 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter between VGA prefetch slots and one requester
module vga_fb_arbiter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int COLOR_W     = 12,
  parameter int BLANK_ONLY  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        H_counter,
  input  logic [9:0]         V_counter,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  input  logic               req,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [COLOR_W-1:0] req_wdata,
  output logic               req_ack,
  output logic [COLOR_W-1:0] req_rdata,
  output logic [COLOR_W-1:0] rgb,
  output logic               blank,
  output logic               frame_start
);

  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;

  state_t      state;
  logic        req_we_q;
  logic        slot_q;

  logic [9:0]  px;
  logic [1:0]  phase;
  logic [9:0]  tx;
  logic [9:0]  ty;
  logic        h_valid;
  logic        v_valid;
  logic        slot;
  logic        slot_active;
  logic        in_vblank;
  logic        blank_ok;
  logic        grant;
  logic [ADDR_W-1:0] disp_addr;

  assign px      = H_counter[11:2];
  assign phase   = H_counter[1:0];
  assign h_valid = (H_counter <= 12'd3199);
  assign v_valid = (V_counter <= 10'd520);

  // Each slot fetches the pixel after the current one; the last slots of a line look ahead to the next line.
  assign tx = (px == 10'd799) ? 10'd0 : px + 10'd1;
  assign ty = (H_counter < 12'd3196) ? V_counter
            : ((V_counter == 10'd520) ? 10'd0 : V_counter + 10'd1);

  assign slot        = (phase == 2'd2) && h_valid && v_valid;
  assign slot_active = slot && (32'(tx) < 32'(H_ACTIVE)) && (32'(ty) < 32'(V_ACTIVE));

  assign disp_addr = ADDR_W'((32'(ty) >> SCALE_SHIFT) * (32'(H_ACTIVE) >> SCALE_SHIFT)
                             + (32'(tx) >> SCALE_SHIFT));

  assign in_vblank = (32'(V_counter) >= 32'(V_ACTIVE)) && (V_counter <= 10'd519);
  assign blank_ok  = (BLANK_ONLY == 0) || in_vblank;
  assign grant     = (state == IDLE) && req && !slot_active && blank_ok;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (slot_active) begin
      mem_addr = disp_addr;
    end else if (grant) begin
      mem_addr  = req_addr;
      mem_we    = req_we;
      mem_wdata = req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_we_q    <= 1'b0;
      req_ack     <= 1'b0;
      req_rdata   <= '0;
      rgb         <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      slot_q      <= 1'b0;
    end else begin
      slot_q      <= slot_active;
      frame_start <= (H_counter == 12'd3199) && (V_counter == 10'd520);

      // Slot data returns during phase 3, so the pixel updates as phase wraps to 0.
      if (phase == 2'd3) begin
        rgb   <= slot_q ? mem_rdata : '0;
        blank <= !slot_q;
      end

      unique case (state)
        IDLE: begin
          req_ack <= 1'b0;
          if (grant) begin
            req_we_q <= req_we;
            state    <= DATA;
          end
        end
        DATA: begin
          if (!req_we_q) begin
            req_rdata <= mem_rdata;
          end
          req_ack <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          req_ack <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          req_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] H_counter;
  logic [9:0]  V_counter;

  logic [14:0] mem_addr, req_addr, mem_addr2, req_addr2;
  logic        mem_we, req, req_we, req_ack, blank, frame_start;
  logic        mem_we2, req2, req_we2, req_ack2, blank2, frame_start2;
  logic [11:0] mem_wdata, mem_rdata, req_wdata, req_rdata, rgb;
  logic [11:0] mem_wdata2, mem_rdata2, req_wdata2, req_rdata2, rgb2;

  logic [11:0] fb [0:32767];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata2 = 12'h000;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .H_counter(H_counter), .V_counter(V_counter),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_rdata(req_rdata), .rgb(rgb), .blank(blank),
    .frame_start(frame_start)
  );

  vga_fb_arbiter #(.BLANK_ONLY(1)) dut_bo (
    .clk(clk), .reset(reset), .H_counter(H_counter), .V_counter(V_counter),
    .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .req(req2), .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .req_ack(req_ack2), .req_rdata(req_rdata2), .rgb(rgb2), .blank(blank2),
    .frame_start(frame_start2)
  );

  // Synchronous single-port framebuffer, preloaded while reset is held.
  always @(posedge clk) begin
    if (reset) begin
      fb[0] <= 12'hF00;
      fb[1] <= 12'h0F0;
    end else if (mem_we) begin
      fb[mem_addr] <= mem_wdata;
    end
    mem_rdata <= fb[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (H_counter == 12'd3199) begin
      H_counter = 12'd0;
      V_counter = (V_counter == 10'd520) ? 10'd0 : V_counter + 10'd1;
    end else begin
      H_counter = H_counter + 12'd1;
    end
    #1;
  endtask

  task automatic set_hv(input int h, input int v);
    H_counter = 12'(h);
    V_counter = 10'(v);
    #1;
  endtask

  initial begin
    int n, bad, upd, fs, grants;
    reset = 1'b1;
    H_counter = 12'd400; V_counter = 10'd200;
    req = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
    repeat (3) tick();
    check("rst_rgb", rgb, 0);
    check("rst_blank", blank, 1);
    check("rst_ack", req_ack, 0);
    check("rst_rdata", req_rdata, 0);
    check("rst_fs", frame_start, 0);

    // Release during a phase-0 cycle with req held: grant now, ack two edges later.
    tick();
    reset = 1'b0;
    #1;
    n = 0;
    while (!req_ack && n < 10) begin
      tick();
      n++;
    end
    check("first_ack_lat", n, 2);
    check("first_rdata", req_rdata, 12'hF00);
    req = 1'b0;

    // Prefetch of (0,0) at the end of the last line, then line 0.
    set_hv(3196, 520);
    tick(); tick();
    check("wrap_slot_addr", mem_addr, 0);
    check("wrap_slot_we", mem_we, 0);
    tick(); tick();
    bad = 0; upd = 0; fs = 0;
    for (int i = 0; i < 3200; i++) begin
      if (H_counter < 16 && (rgb !== 12'hF00 || blank !== 1'b0)) bad++;
      if (H_counter == 0) check("fs_pulse", frame_start, 1);
      if (H_counter == 1) check("fs_clear", frame_start, 0);
      if (H_counter == 16) check("px4_rgb", rgb, 12'h0F0);
      if (H_counter[1:0] == 2'd0 && blank == 1'b0) upd++;
      if (frame_start) fs++;
      tick();
    end
    check("px0_3_rgb_blank", bad, 0);
    check("line0_updates", upd, 640);
    check("line0_fs_count", fs, 1);

    // End of the last visible line and the first blanking line.
    set_hv(2540, 479);
    bad = 0;
    for (int i = 0; i < 3860; i++) begin
      if (V_counter == 479 && H_counter == 2559) check("l479_last_blank", blank, 0);
      if (V_counter == 479 && H_counter == 2560) begin
        check("l479_end_rgb", rgb, 0);
        check("l479_end_blank", blank, 1);
      end
      if ((V_counter == 479 && H_counter > 2560) || V_counter == 480)
        if (blank !== 1'b1 || rgb !== 12'h000 || mem_addr !== 15'd0) bad++;
      tick();
    end
    check("vblank_no_slots", bad, 0);

    // Write arriving on a slot cycle waits one cycle, then read back.
    set_hv(2, 10);
    req = 1'b1; req_we = 1'b1; req_addr = 15'h0005; req_wdata = 12'hABC;
    #1;
    check("wr_slot_we", mem_we, 0);
    check("wr_slot_addr", mem_addr, 320);
    tick();
    check("wr_grant_we", mem_we, 1);
    check("wr_grant_addr", mem_addr, 5);
    check("wr_grant_wdata", mem_wdata, 12'hABC);
    tick();
    check("wr_data_ack", req_ack, 0);
    check("wr_data_we", mem_we, 0);
    tick();
    check("wr_ack", req_ack, 1);
    req_we = 1'b0;
    tick();
    check("rd_slot_addr", mem_addr, 320);
    check("rd_ack_pulse", req_ack, 0);
    tick();
    check("rd_grant_addr", mem_addr, 5);
    check("rd_grant_we", mem_we, 0);
    tick();
    check("rd_data_ack", req_ack, 0);
    tick();
    check("rd_ack", req_ack, 1);
    check("rd_rdata", req_rdata, 12'hABC);
    req = 1'b0;
    tick();
    check("rd_ack_end", req_ack, 0);

    // Vertical-blank-only requester.
    set_hv(0, 100);
    req2 = 1'b1; req_we2 = 1'b1; req_addr2 = 15'd7; req_wdata2 = 12'h123;
    #1;
    grants = 0;
    repeat (40) begin
      if (mem_we2) grants++;
      tick();
    end
    check("bo_active_nogrant", grants, 0);
    set_hv(3190, 479);
    n = 0;
    while (!mem_we2 && n < 50) begin
      tick();
      n++;
    end
    check("bo_grant_v", V_counter, 480);
    check("bo_grant_h", H_counter, 0);
    check("bo_grant_addr", mem_addr2, 7);
    check("bo_grant_wdata", mem_wdata2, 12'h123);
    tick(); tick();
    check("bo_ack", req_ack2, 1);
    req2 = 1'b0;
    tick();

    set_hv(3180, 520);
    req2 = 1'b1;
    #1;
    grants = 0;
    repeat (60) begin
      if (mem_we2) grants++;
      tick();
    end
    check("bo_v520_nogrant", grants, 0);
    set_hv(3196, 479);
    n = 0;
    while (!mem_we2 && n < 50) begin
      tick();
      n++;
    end
    check("bo_regrant_v", V_counter, 480);
    check("bo_regrant_h", H_counter, 0);
    tick(); tick();
    check("bo_ack2", req_ack2, 1);
    check("bo_rdata_kept", req_rdata2, 0);
    req2 = 1'b0;
    tick();
    check("bo_rgb_dark", {20'd0, rgb2}, 0);
    check("bo_blank", blank2, 1);
    check("bo_fs_idle", frame_start2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
